// File: rtl/powlib_busrrarb.sv
// rtl/powlib_busrrarb.sv - round-robin arbiter sharing one powlib bus among B_WRS requesters
// Optional per-lane beat and stall counters: define POWLIB_BUSRRARB_STATS_EN.
module powlib_busrrarb #(
   parameter int B_WRS = 4,
   parameter int B_AW  = 2,
   parameter int B_DW  = 4,
   parameter int BURST = 4,
   parameter int EAR   = 1,
   parameter     ID    = "BUSRRARB",
   parameter int EDBG  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [B_WRS*B_DW-1:0] wrdatas,
   input  logic [B_WRS*B_AW-1:0] wraddrs,
   input  logic [B_WRS-1:0]      wrvlds,
   output logic [B_WRS-1:0]      wrrdys,
   output logic [B_DW-1:0]       rddata,
   output logic [B_AW-1:0]       rdaddr,
   output logic                  rdvld,
   input  logic                  rdrdy
);
   localparam int PW = $clog2(B_WRS);
   localparam int CW = $clog2(BURST + 1);

   if (B_WRS < 2 || BURST < 1 || EAR != 1 || EDBG < 0) begin : g_bad_param
      $error("%s: unsupported parameter set", ID);
   end

   typedef enum logic {S_IDLE, S_LOCK} state_t;

   state_t          r_state;
   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   r_owner;
   logic [CW-1:0]   r_cnt;
   logic            r_rdvld;
   logic [B_DW-1:0] r_rddata;
   logic [B_AW-1:0] r_rdaddr;

   logic             w_acc;
   logic             w_found;
   logic             w_xfer;
   logic [PW-1:0]    w_g;
   logic [PW-1:0]    w_idx;
   logic [PW-1:0]    w_sel;
   logic [B_WRS-1:0] w_rdys;

   function automatic logic [PW-1:0] f_next(input logic [PW-1:0] x);
      return (x == PW'(B_WRS - 1)) ? '0 : x + 1'b1;
   endfunction

   function automatic logic [PW-1:0] f_wrap(input logic [PW-1:0] p, input int k);
      int j;
      j = int'(p) + k;
      if (j >= B_WRS) j = j - B_WRS;
      return PW'(j);
   endfunction

   assign w_acc = !r_rdvld || rdrdy;

   // Walk the scan order backwards so the last hit is the first lane after ptr.
   always_comb begin
      w_found = 1'b0;
      w_g     = r_ptr;
      w_idx   = r_ptr;
      for (int k = B_WRS - 1; k >= 0; k--) begin
         w_idx = f_wrap(r_ptr, k);
         if (wrvlds[w_idx]) begin
            w_found = 1'b1;
            w_g     = w_idx;
         end
      end
   end

   always_comb begin
      w_rdys = '0;
      w_sel  = (r_state == S_LOCK) ? r_owner : w_g;
      if (r_state == S_LOCK) begin
         if (w_acc && wrvlds[r_owner]) w_rdys[r_owner] = 1'b1;
      end else if (w_acc && w_found) begin
         w_rdys[w_g] = 1'b1;
      end
   end

   assign wrrdys = rst ? w_rdys : '0;
   assign w_xfer = |(wrvlds & wrrdys);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_ptr    <= '0;
         r_owner  <= '0;
         r_cnt    <= '0;
         r_rdvld  <= 1'b0;
         r_rddata <= '0;
         r_rdaddr <= '0;
      end else begin
         if (w_acc) begin
            r_rdvld <= w_xfer;
            if (w_xfer) begin
               r_rddata <= wrdatas[w_sel*B_DW +: B_DW];
               r_rdaddr <= wraddrs[w_sel*B_AW +: B_AW];
            end
         end
         case (r_state)
            S_IDLE: begin
               if (w_xfer) begin
                  if (BURST == 1) begin
                     r_ptr <= f_next(w_g);
                  end else begin
                     r_owner <= w_g;
                     r_cnt   <= CW'(1);
                     r_state <= S_LOCK;
                  end
               end
            end
            S_LOCK: begin
               if (w_acc) begin
                  if (wrvlds[r_owner]) begin
                     r_cnt <= r_cnt + 1'b1;
                     if (r_cnt + 1'b1 == CW'(BURST)) begin
                        r_ptr   <= f_next(r_owner);
                        r_state <= S_IDLE;
                     end
                  end else begin
                     // Owner went idle: release now, re-arbitrate next cycle.
                     r_ptr   <= f_next(r_owner);
                     r_state <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rddata = r_rddata;
   assign rdaddr = r_rdaddr;
   assign rdvld  = r_rdvld;

`ifdef POWLIB_BUSRRARB_STATS_EN
   logic [15:0] stat_beats [B_WRS];
   logic [15:0] stall_cycles;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < B_WRS; i++) stat_beats[i] <= '0;
         stall_cycles <= '0;
      end else begin
         for (int i = 0; i < B_WRS; i++) begin
            if (wrvlds[i] && wrrdys[i] && stat_beats[i] != 16'hFFFF)
               stat_beats[i] <= stat_beats[i] + 1'b1;
         end
         if (r_rdvld && !rdrdy && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_powlib_busrrarb.sv
// tb/tb_powlib_busrrarb.sv - table-driven scoreboard bench for powlib_busrrarb
module tb_powlib_busrrarb;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] wrdatas = 16'h3210;
   logic [7:0]  wraddrs = 8'b11_10_01_00;
   logic [3:0]  wrvlds = 4'h0;
   logic        rdrdy = 1'b1;

   logic [3:0] rdys_a, rdys_b, data_a, data_b;
   logic [1:0] addr_a, addr_b;
   logic       vld_a, vld_b;

   powlib_busrrarb #(.B_WRS(4), .B_AW(2), .B_DW(4), .BURST(4)) dut_a (
      .clk(clk), .rst(rst), .wrdatas(wrdatas), .wraddrs(wraddrs), .wrvlds(wrvlds),
      .wrrdys(rdys_a), .rddata(data_a), .rdaddr(addr_a), .rdvld(vld_a), .rdrdy(rdrdy));

   powlib_busrrarb #(.B_WRS(4), .B_AW(2), .B_DW(4), .BURST(1)) dut_b (
      .clk(clk), .rst(rst), .wrdatas(wrdatas), .wraddrs(wraddrs), .wrvlds(wrvlds),
      .wrrdys(rdys_b), .rddata(data_b), .rdaddr(addr_b), .rdvld(vld_b), .rdrdy(rdrdy));

   always #5 clk = ~clk;

   typedef struct {
      bit         do_reset;
      bit         sel;
      logic [3:0] vld;
      logic       rdy;
      logic [3:0] exp;
   } vec_t;

   vec_t       vq[$];
   logic [1:0] sb[$];
   int         n_tests = 0;
   int         n_fail  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void add(input bit r, input bit s, input logic [3:0] v,
                               input logic rd, input logic [3:0] e);
      vec_t t;
      t.do_reset = r; t.sel = s; t.vld = v; t.rdy = rd; t.exp = e;
      vq.push_back(t);
   endfunction

   function automatic logic [1:0] lane_of(input logic [3:0] oh);
      logic [1:0] l;
      l = 2'd0;
      for (int i = 0; i < 4; i++) if (oh[i]) l = 2'(i);
      return l;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; wrvlds = 4'h0; rdrdy = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      sb.delete();
   endtask

   task automatic run_vecs(input string tag);
      vec_t       v;
      logic [3:0] r, d;
      logic [1:0] a;
      logic       vl;
      foreach (vq[n]) begin
         v = vq[n];
         if (v.do_reset) do_reset();
         @(negedge clk);
         wrvlds = v.vld; rdrdy = v.rdy;
         #1;
         r  = v.sel ? rdys_b : rdys_a;
         d  = v.sel ? data_b : data_a;
         a  = v.sel ? addr_b : addr_a;
         vl = v.sel ? vld_b  : vld_a;
         check($sformatf("%s[%0d] wrrdys", tag, n), int'(r), int'(v.exp));
         check($sformatf("%s[%0d] rdvld", tag, n), int'(vl), int'(sb.size() != 0));
         if (vl && sb.size() != 0) begin
            check($sformatf("%s[%0d] rddata", tag, n), int'(d), int'(sb[0]));
            check($sformatf("%s[%0d] rdaddr", tag, n), int'(a), int'(sb[0]));
            if (v.rdy) void'(sb.pop_front());
         end
         if (v.exp != 4'h0) sb.push_back(lane_of(v.exp));
      end
      vq.delete();
   endtask

`ifdef POWLIB_BUSRRARB_STATS_EN
   task automatic stat_run(input int lane, input int n);
      int cnt, c;
      cnt = 0; c = 0;
      while (cnt < n && c < 4 * n) begin
         @(negedge clk);
         wrvlds = 4'b0001 << lane; rdrdy = 1'b1;
         #1;
         if (rdys_a[lane]) cnt++;
         c++;
      end
      @(posedge clk); #1;
      wrvlds = 4'h0;
      check($sformatf("stat lane%0d beats driven", lane), cnt, n);
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      wrvlds = 4'hF;
      @(posedge clk); #1;
      check("reset rdvld", int'(vld_a), 0);
      check("reset wrrdys", int'(rdys_a), 0);
      check("reset rddata", int'(data_a), 0);
      check("reset rdaddr", int'(addr_a), 0);

      // Fair rotation, 4 beats per lane.
      for (int i = 0; i < 17; i++) add(i == 0, 1'b0, 4'hF, 1'b1, 4'b0001 << ((i / 4) % 4));
      run_vecs("rr_burst4");

      // Per-beat round robin between lanes 1 and 3.
      add(1, 1, 4'b1010, 1, 4'b0010);
      for (int i = 0; i < 5; i++) add(0, 1, 4'b1010, 1, (i % 2 == 0) ? 4'b1000 : 4'b0010);
      run_vecs("rr_burst1");

      // Owner drops early: bubble, then scan resumes after the owner.
      add(1, 0, 4'b0100, 1, 4'b0100);
      add(0, 0, 4'b0101, 1, 4'b0100);
      add(0, 0, 4'b0001, 1, 4'b0000);
      add(0, 0, 4'b1001, 1, 4'b1000);
      add(0, 0, 4'b0001, 1, 4'b0000);
      add(0, 0, 4'b0001, 1, 4'b0001);
      add(0, 0, 4'b0000, 1, 4'b0000);
      run_vecs("early_release");

      // Downstream stall holds the output and blocks grants.
      add(1, 0, 4'b0100, 1, 4'b0100);
      for (int i = 0; i < 5; i++) add(0, 0, 4'b0100, 0, 4'b0000);
      add(0, 0, 4'b0100, 1, 4'b0100);
      add(0, 0, 4'b0000, 1, 4'b0000);
      run_vecs("stall");

      // Full burst on lane 1 (ptr -> 2), then two beats into a second burst.
      for (int i = 0; i < 6; i++) add(i == 0, 0, 4'b0010, 1, 4'b0010);
      run_vecs("pre_reset");
      @(posedge clk); #2;
      check("mid-burst rdvld", int'(vld_a), 1);
      rst = 1'b0; wrvlds = 4'h0;
      #1;
      check("async reset rdvld", int'(vld_a), 0);
      check("async reset wrrdys", int'(rdys_a), 0);
      sb.delete();
      @(negedge clk);
      rst = 1'b1;
      add(0, 0, 4'b1010, 1, 4'b0010);
      add(0, 0, 4'b0000, 1, 4'b0000);
      run_vecs("post_reset");

`ifdef POWLIB_BUSRRARB_STATS_EN
      do_reset();
      stat_run(0, 10);
      stat_run(2, 6);
      @(negedge clk); #1;
      check("stat_beats[0]", int'(dut_a.stat_beats[0]), 10);
      check("stat_beats[1]", int'(dut_a.stat_beats[1]), 0);
      check("stat_beats[2]", int'(dut_a.stat_beats[2]), 6);
      check("stat_beats[3]", int'(dut_a.stat_beats[3]), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
